bus_grant_controller: RTL and testbench

//  Downstream stage of the strict-priority arbiter. Latches the winning channel

---
 rtl/bus_grant_controller.sv | 131 +++++++++++++
 tb/tb_bus_grant_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_controller.sv
// Grant stage behind a strict-priority arbiter: grants the winning client,
// forwards up to one burst of its words to the server and acks the arbiter on release.
module bus_grant_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              address_to_be_served,
    input  logic                    addr_valid,
    input  logic [3:0]              client_rq,
    input  logic [4*DATA_WIDTH-1:0] client_data,
    output logic [3:0]              client_grant,
    output logic [3:0]              client_ack,
    output logic [DATA_WIDTH-1:0]   server_data,
    output logic                    server_valid,
    input  logic                    server_ready,
    output logic                    server_ack,
    output logic                    timeout_err
);

    localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(MAX_BURST);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [1:0]           addr, addr_n;
    logic [BEAT_W-1:0]    beat_cnt, beat_cnt_n, beat_inc;
    logic [STALL_W-1:0]   stall_cnt, stall_cnt_n, stall_inc;
    logic [3:0]           grant_n;
    logic [DATA_WIDTH-1:0] words [4];

    // Unpack the flat client data bus into per-client words.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            words[i] = client_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Saturating increments of both counters.
    always_comb begin
        beat_inc  = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + BEAT_W'(1);
        stall_inc = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= 2'd0;
            beat_cnt     <= '0;
            stall_cnt    <= '0;
            client_grant <= 4'd0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            beat_cnt     <= beat_cnt_n;
            stall_cnt    <= stall_cnt_n;
            client_grant <= grant_n;
        end
    end

    // Next-state and handshake outputs; a beat takes priority over a timeout.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        beat_cnt_n   = beat_cnt;
        stall_cnt_n  = stall_cnt;
        grant_n      = client_grant;
        server_valid = 1'b0;
        server_data  = '0;
        client_ack   = 4'd0;
        server_ack   = 1'b0;
        timeout_err  = 1'b0;

        case (state)
            IDLE: begin
                if (addr_valid) begin
                    addr_n      = address_to_be_served;
                    beat_cnt_n  = '0;
                    stall_cnt_n = '0;
                    if (client_rq[address_to_be_served]) begin
                        state_n = GRANT;
                        grant_n = 4'd1 << address_to_be_served;
                    end else begin
                        state_n = RELEASE;
                    end
                end
            end
            GRANT: begin
                server_valid = client_rq[addr];
                server_data  = words[addr];
                if (!client_rq[addr]) begin
                    state_n = RELEASE;
                    grant_n = 4'd0;
                end else if (server_ready) begin
                    client_ack  = 4'd1 << addr;
                    beat_cnt_n  = beat_inc;
                    stall_cnt_n = '0;
                    if (beat_inc == BEAT_MAX) begin
                        state_n = RELEASE;
                        grant_n = 4'd0;
                    end
                end else begin
                    stall_cnt_n = stall_inc;
                    if (stall_inc == STALL_MAX) begin
                        timeout_err = 1'b1;
                        state_n     = RELEASE;
                        grant_n     = 4'd0;
                    end
                end
            end
            RELEASE: begin
                server_ack = 1'b1;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Bench for bus_grant_controller: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_bus_grant_controller;

    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address_to_be_served;
    logic          addr_valid;
    logic [3:0]    client_rq;
    logic [4*DW-1:0] client_data;
    logic          server_ready;

    logic [3:0]    client_grant, client_ack;
    logic [DW-1:0] server_data;
    logic          server_valid, server_ack, timeout_err;

    logic [3:0]    g1_grant, g1_ack;
    logic [DW-1:0] g1_data;
    logic          g1_valid, g1_sack, g1_terr;

    always #5 clk = ~clk;

    bus_grant_controller #(.DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .address_to_be_served(address_to_be_served), .addr_valid(addr_valid),
        .client_rq(client_rq), .client_data(client_data),
        .client_grant(client_grant), .client_ack(client_ack),
        .server_data(server_data), .server_valid(server_valid),
        .server_ready(server_ready), .server_ack(server_ack),
        .timeout_err(timeout_err)
    );

    bus_grant_controller #(.DATA_WIDTH(DW), .MAX_BURST(1), .TIMEOUT(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .address_to_be_served(address_to_be_served), .addr_valid(addr_valid),
        .client_rq(client_rq), .client_data(client_data),
        .client_grant(g1_grant), .client_ack(g1_ack),
        .server_data(g1_data), .server_valid(g1_valid),
        .server_ready(server_ready), .server_ack(g1_sack),
        .timeout_err(g1_terr)
    );

    int checks = 0;
    int failures = 0;

    // Model: where the grant is in its life, whom it serves, words moved, stalls in a row.
    int m_phase = 0;   // 0 waiting for a winner, 1 serving, 2 acking the arbiter
    int m_cl = 0;
    int m_beats = 0;
    int m_stalls = 0;

    int nacks = 0;
    int nterr = 0;
    int nsack = 0;
    logic [DW-1:0] beat_q [$];
    logic [3:0] s1_grant, s1_ack;
    logic s1_terr, s1_sack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int c);
        return client_data[c*DW +: DW];
    endfunction

    task automatic sample_and_check();
        logic [3:0] eg, ea;
        logic ev, es, et;
        logic [DW-1:0] ed;
        if (!reset_n) m_phase = 0;
        eg = (m_phase == 1) ? 4'(1 << m_cl) : 4'd0;
        ev = (m_phase == 1) && client_rq[m_cl];
        ed = (m_phase == 1) ? word_of(m_cl) : '0;
        ea = (ev && server_ready) ? eg : 4'd0;
        es = (m_phase == 2);
        et = ev && !server_ready && (m_stalls + 1 == int'(TO));
        check("grant", 32'(client_grant), 32'(eg));
        check("valid", 32'(server_valid), 32'(ev));
        check("data",  32'(server_data),  32'(ed));
        check("cack",  32'(client_ack),   32'(ea));
        check("sack",  32'(server_ack),   32'(es));
        check("terr",  32'(timeout_err),  32'(et));
        if (client_ack != 4'd0) nacks++;
        if (timeout_err) nterr++;
        if (server_ack) nsack++;
        if (server_valid && server_ready) beat_q.push_back(server_data);
        s1_grant = g1_grant;
        s1_ack   = g1_ack;
        s1_terr  = g1_terr;
        s1_sack  = g1_sack;
    endtask

    task automatic model_update();
        if (!reset_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (addr_valid) begin
                    m_cl = int'(address_to_be_served);
                    m_beats = 0;
                    m_stalls = 0;
                    m_phase = client_rq[m_cl] ? 1 : 2;
                end
                1: begin
                    if (!client_rq[m_cl]) m_phase = 2;
                    else if (server_ready) begin
                        m_beats++;
                        m_stalls = 0;
                        if (m_beats == int'(MB)) m_phase = 2;
                    end else begin
                        m_stalls++;
                        if (m_stalls == int'(TO)) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_and_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_counts();
        nacks = 0;
        nterr = 0;
        nsack = 0;
        beat_q.delete();
    endtask

    task automatic start_grant(input logic [1:0] a, input logic [3:0] rq, input logic rdy);
        address_to_be_served = a;
        client_rq = rq;
        server_ready = rdy;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, then idle after release.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_valid = 1'($urandom);
            address_to_be_served = 2'($urandom);
            client_rq = 4'($urandom);
            client_data = 32'($urandom);
            server_ready = 1'($urandom);
            tick();
        end
        reset_n = 1'b1;
        addr_valid = 1'b0;
        repeat (3) tick();

        // Full burst of four words to client 3.
        clear_counts();
        start_grant(2'd2, 4'b0100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            client_data = 32'($urandom);
            client_data[2*DW +: DW] = DW'(8'hA0 + k);
            tick();
        end
        tick();
        check("burst_acks", 32'(nacks), 32'd4);
        check("burst_sack", 32'(nsack), 32'd1);
        check("burst_words", 32'(beat_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < beat_q.size(); k++)
            check("burst_word", 32'(beat_q[k]), 32'(8'hA0 + k));

        // Client 1 sends two words then drops its request.
        clear_counts();
        start_grant(2'd0, 4'b0001, 1'b1);
        repeat (2) tick();
        client_rq = 4'b0000;
        tick();
        tick();
        check("drop_acks", 32'(nacks), 32'd2);
        check("drop_sack", 32'(nsack), 32'd1);
        check("drop_terr", 32'(nterr), 32'd0);

        // Client 4 stalls until the timeout releases it.
        clear_counts();
        start_grant(2'd3, 4'b1000, 1'b0);
        repeat (TO) tick();
        check("to_terr", 32'(nterr), 32'd1);
        tick();
        check("to_sack", 32'(nsack), 32'd1);
        check("to_acks", 32'(nacks), 32'd0);

        // Empty grant: winner has no request.
        clear_counts();
        start_grant(2'd1, 4'b0000, 1'b1);
        tick();
        check("empty_sack", 32'(nsack), 32'd1);
        check("empty_acks", 32'(nacks), 32'd0);

        // One-word burst with timeout of one: the beat wins over the stall limit.
        client_rq = 4'b0000;
        repeat (3) tick();
        start_grant(2'd1, 4'b0010, 1'b1);
        tick();
        check("b1_grant", 32'(s1_grant), 32'(4'b0010));
        check("b1_ack",   32'(s1_ack),   32'(4'b0010));
        check("b1_terr",  32'(s1_terr),  32'd0);
        tick();
        check("b1_sack",  32'(s1_sack),  32'd1);
        check("b1_gnt0",  32'(s1_grant), 32'd0);
        repeat (4) tick();

        // Reset in the middle of a burst, then a fresh burst.
        start_grant(2'd2, 4'b0100, 1'b1);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("rst_grant", 32'(client_grant), 32'd0);
        check("rst_valid", 32'(server_valid), 32'd0);
        check("rst_cack",  32'(client_ack),   32'd0);
        check("rst_sack",  32'(server_ack),   32'd0);
        m_phase = 0;
        tick();
        reset_n = 1'b1;
        tick();
        clear_counts();
        start_grant(2'd2, 4'b0100, 1'b1);
        repeat (5) tick();
        check("rst_burst_acks", 32'(nacks), 32'd4);
        check("rst_burst_sack", 32'(nsack), 32'd1);

        // Random traffic: mostly-ready server first, then a stalling one.
        for (int i = 0; i < 700; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            addr_valid = ($urandom_range(0, 9) < 3);
            address_to_be_served = 2'($urandom);
            for (int b = 0; b < 4; b++) client_rq[b] = ($urandom_range(0, 99) < 88);
            client_data = 32'($urandom);
            server_ready = (i < 350) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
